// File: rtl/dds_sweep_ctrl_if.sv
// Configuration and sweep-output bundle between the host and the DDS sweep sequencer.
interface dds_sweep_ctrl_if #(
  parameter int unsigned FW = 32,
  parameter int unsigned NW = 16
);
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [FW-1:0] cfg_data;
  logic          start;
  logic          abort;
  logic [FW-1:0] f1_word;
  logic [FW-1:0] f2_word;
  logic          phase_clr;
  logic          busy;
  logic          done;
  logic [NW-1:0] step_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, abort,
    input  f1_word, f2_word, phase_clr, busy, done, step_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, abort,
    output f1_word, f2_word, phase_clr, busy, done, step_idx
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Two-tone DDS sweep sequencer: steps the primary frequency word with a fixed dwell,
// holds the secondary word, and clears both phase accumulators at sweep start.
module dds_sweep_ctrl #(
  parameter int unsigned FW = 32,
  parameter int unsigned NW = 16,
  parameter int unsigned DW = 24
) (
  input  logic           clk,
  input  logic           reset,
  dds_sweep_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] A_F1_START = 3'd0;
  localparam logic [2:0] A_F1_STEP  = 3'd1;
  localparam logic [2:0] A_F2_FIXED = 3'd2;
  localparam logic [2:0] A_NSTEPS   = 3'd3;
  localparam logic [2:0] A_DWELL    = 3'd4;

  logic [FW-1:0] f1_start_q, f1_start_d;
  logic [FW-1:0] f1_step_q,  f1_step_d;
  logic [FW-1:0] f2_fixed_q, f2_fixed_d;
  logic [NW-1:0] nsteps_q,   nsteps_d;
  logic [DW-1:0] dwell_q,    dwell_d;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] f1_word_q, f1_word_d;
  logic [FW-1:0] f2_word_q, f2_word_d;
  logic          phase_clr_q, phase_clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [NW-1:0] step_idx_q, step_idx_d;

  logic [DW-1:0] dwell_m1_c;
  logic          last_step_c;

  // Remaining-cycle reload value; a zero dwell behaves as a one-cycle dwell.
  assign dwell_m1_c  = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
  assign last_step_c = (step_idx_q == nsteps_q - NW'(1));

  // Register file; frozen while a sweep is running.
  always_comb begin
    f1_start_d = f1_start_q;
    f1_step_d  = f1_step_q;
    f2_fixed_d = f2_fixed_q;
    nsteps_d   = nsteps_q;
    dwell_d    = dwell_q;
    if (bus.cfg_we && !busy_q) begin
      case (bus.cfg_addr)
        A_F1_START: f1_start_d = bus.cfg_data;
        A_F1_STEP:  f1_step_d  = bus.cfg_data;
        A_F2_FIXED: f2_fixed_d = bus.cfg_data;
        A_NSTEPS:   nsteps_d   = bus.cfg_data[NW-1:0];
        A_DWELL:    dwell_d    = bus.cfg_data[DW-1:0];
        default:    ;
      endcase
    end
  end

  // Next state and next registered outputs; idle values are the defaults.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f1_word_d   = '0;
    f2_word_d   = '0;
    phase_clr_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    step_idx_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (nsteps_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_CLEAR;
            phase_clr_d = 1'b1;
            busy_d      = 1'b1;
            f1_word_d   = f1_start_q;
            f2_word_d   = f2_fixed_q;
            cnt_d       = dwell_m1_c;
          end
        end
      end
      S_CLEAR, S_DWELL: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0 && last_step_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_DWELL;
          busy_d     = 1'b1;
          f2_word_d  = f2_word_q;
          f1_word_d  = f1_word_q;
          step_idx_d = step_idx_q;
          if (cnt_q == '0) begin
            f1_word_d  = f1_word_q + f1_step_q;
            step_idx_d = step_idx_q + NW'(1);
            cnt_d      = dwell_m1_c;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f1_start_q  <= '0;
      f1_step_q   <= '0;
      f2_fixed_q  <= '0;
      nsteps_q    <= '0;
      dwell_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f1_word_q   <= '0;
      f2_word_q   <= '0;
      phase_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_idx_q  <= '0;
    end else begin
      f1_start_q  <= f1_start_d;
      f1_step_q   <= f1_step_d;
      f2_fixed_q  <= f2_fixed_d;
      nsteps_q    <= nsteps_d;
      dwell_q     <= dwell_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f1_word_q   <= f1_word_d;
      f2_word_q   <= f2_word_d;
      phase_clr_q <= phase_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_idx_q  <= step_idx_d;
    end
  end

  assign bus.f1_word   = f1_word_q;
  assign bus.f2_word   = f2_word_q;
  assign bus.phase_clr = phase_clr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_idx  = step_idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a timeline model of the sweep checked every cycle,
// plus hand-computed literal checkpoints for the directed scenarios.
module tb_dds_sweep_ctrl;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  dds_sweep_ctrl_if #(.FW(32), .NW(16)) bus ();

  dds_sweep_ctrl #(.FW(32), .NW(16), .DW(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sweep is a timeline of N*D busy cycles followed by one done cycle.
  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_DONE = 2;

  logic [31:0] m_cfg [0:4] = '{default: 32'd0};
  int          m_mode = M_IDLE;
  longint      m_n = 0;
  longint      m_N = 0;
  longint      m_D = 1;
  logic [31:0] m_f1s = 0, m_f1i = 0, m_f2 = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cfg  <= '{default: 32'd0};
      m_mode <= M_IDLE;
      m_n    <= 0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.start && !bus.abort) begin
          if (m_cfg[3][15:0] == 16'd0) m_mode <= M_DONE;
          else begin
            m_mode <= M_ACT;
            m_n    <= 1;
            m_N    <= longint'(m_cfg[3][15:0]);
            m_D    <= (m_cfg[4][23:0] == 24'd0) ? 1 : longint'(m_cfg[4][23:0]);
            m_f1s  <= m_cfg[0];
            m_f1i  <= m_cfg[1];
            m_f2   <= m_cfg[2];
          end
        end
        M_ACT: begin
          if (bus.abort)          m_mode <= M_IDLE;
          else if (m_n == m_N * m_D) m_mode <= M_DONE;
          else                    m_n <= m_n + 1;
        end
        default: m_mode <= M_IDLE;
      endcase
      if (bus.cfg_we && m_mode != M_ACT && bus.cfg_addr <= 3'd4)
        m_cfg[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic [31:0] e_f1, e_f2, e_idx;
      logic        e_busy, e_done, e_pc;
      longint      k;
      e_f1 = 0; e_f2 = 0; e_idx = 0; e_busy = 0; e_done = 0; e_pc = 0;
      if (m_mode == M_ACT) begin
        k      = (m_n - 1) / m_D;
        e_f1   = m_f1s + 32'(k) * m_f1i;
        e_f2   = m_f2;
        e_idx  = 32'(k);
        e_busy = 1'b1;
        e_pc   = (m_n == 1);
      end else if (m_mode == M_DONE) begin
        e_done = 1'b1;
      end
      chk("model f1_word",   bus.f1_word,          e_f1);
      chk("model f2_word",   bus.f2_word,          e_f2);
      chk("model step_idx",  32'(bus.step_idx),    e_idx);
      chk("model busy",      32'(bus.busy),        32'(e_busy));
      chk("model done",      32'(bus.done),        32'(e_done));
      chk("model phase_clr", 32'(bus.phase_clr),   32'(e_pc));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input logic [31:0] f1s, input logic [31:0] f1i, input logic [31:0] f2,
                         input logic [31:0] n, input logic [31:0] dw);
    wr(3'd0, f1s); wr(3'd1, f1i); wr(3'd2, f2); wr(3'd3, n); wr(3'd4, dw);
  endtask

  // One-cycle start; returns at the first cycle showing the start response.
  task automatic go();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0; bus.start = 0; bus.abort = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    cyc(3);
    chk("reset f1_word", bus.f1_word, 32'd0);
    chk("reset f2_word", bus.f2_word, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset phase_clr", 32'(bus.phase_clr), 32'd0);
    chk("reset step_idx", 32'(bus.step_idx), 32'd0);
    reset = 1'b0;
    cyc(1);

    // Nominal sweep
    cfg_all(32'd85899, 32'd85899, 32'd1803886, 32'd3, 32'd4);
    go();
    chk("nom c1 f1", bus.f1_word, 32'd85899);
    chk("nom c1 f2", bus.f2_word, 32'd1803886);
    chk("nom c1 phase_clr", 32'(bus.phase_clr), 32'd1);
    chk("nom c1 busy", 32'(bus.busy), 32'd1);
    cyc(4);
    chk("nom c5 f1", bus.f1_word, 32'd171798);
    chk("nom c5 step", 32'(bus.step_idx), 32'd1);
    chk("nom c5 phase_clr", 32'(bus.phase_clr), 32'd0);
    cyc(4);
    chk("nom c9 f1", bus.f1_word, 32'd257697);
    cyc(3);
    chk("nom c12 busy", 32'(bus.busy), 32'd1);
    cyc(1);
    chk("nom c13 done", 32'(bus.done), 32'd1);
    chk("nom c13 busy", 32'(bus.busy), 32'd0);
    chk("nom c13 f2", bus.f2_word, 32'd0);
    cyc(1);
    chk("nom c14 done", 32'(bus.done), 32'd0);

    // Wrap of the primary word
    cfg_all(32'hFFFF_FFF0, 32'h20, 32'h1234, 32'd2, 32'd1);
    go();
    chk("wrap c1 f1", bus.f1_word, 32'hFFFF_FFF0);
    cyc(1);
    chk("wrap c2 f1", bus.f1_word, 32'h0000_0010);
    cyc(1);
    chk("wrap c3 done", 32'(bus.done), 32'd1);
    cyc(2);

    // Zero dwell acts as one cycle
    cfg_all(32'd100, 32'd1, 32'd7, 32'd2, 32'd0);
    go();
    chk("dw0 c1 f1", bus.f1_word, 32'd100);
    cyc(1);
    chk("dw0 c2 f1", bus.f1_word, 32'd101);
    chk("dw0 c2 busy", 32'(bus.busy), 32'd1);
    cyc(1);
    chk("dw0 c3 done", 32'(bus.done), 32'd1);
    chk("dw0 c3 busy", 32'(bus.busy), 32'd0);
    cyc(2);

    // Zero steps: done only
    wr(3'd3, 32'd0);
    go();
    chk("n0 c1 done", 32'(bus.done), 32'd1);
    chk("n0 c1 busy", 32'(bus.busy), 32'd0);
    chk("n0 c1 phase_clr", 32'(bus.phase_clr), 32'd0);
    cyc(2);

    // Ignored write and start during busy, then abort
    cfg_all(32'd85899, 32'd85899, 32'd1803886, 32'd3, 32'd4);
    go();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    cyc(3);
    chk("ab c5 f1", bus.f1_word, 32'd171798);
    chk("ab c5 step", 32'(bus.step_idx), 32'd1);
    cyc(1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab c7 f1", bus.f1_word, 32'd0);
    chk("ab c7 f2", bus.f2_word, 32'd0);
    chk("ab c7 busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("ab no done", 32'(bus.done), 32'd0);
      cyc(1);
    end
    go();
    chk("ab restart f1", bus.f1_word, 32'd85899);
    cyc(13);

    // Asynchronous reset mid-dwell
    go();
    cyc(2);
    #2 reset = 1'b1;
    #1;
    chk("arst f1", bus.f1_word, 32'd0);
    chk("arst f2", bus.f2_word, 32'd0);
    chk("arst busy", 32'(bus.busy), 32'd0);
    chk("arst step", 32'(bus.step_idx), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    go();
    chk("post-rst done", 32'(bus.done), 32'd1);
    chk("post-rst busy", 32'(bus.busy), 32'd0);
    chk("post-rst phase_clr", 32'(bus.phase_clr), 32'd0);
    chk("post-rst f2", bus.f2_word, 32'd0);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
